// File: rtl/pio_sm_datapath.sv
// Datapath of one PIO state machine: program counter, TX FIFO feeding the OSR, and RX FIFO.
// Define OSR_AUTOPULL_EN to let the OSR refill itself once its shift count reaches pull_thresh.

module pio_sm_pc (
    input  logic       clk,
    input  logic       rst,
    input  logic       pc_en_i,
    input  logic       jump_en_i,
    input  logic [4:0] jump_i,
    input  logic [4:0] wrap_top_i,
    input  logic [4:0] wrap_bottom_i,
    output logic [4:0] pc_o
);
    logic [4:0] pc_q, pc_d;

    always_comb begin
        pc_d = pc_q;
        if (pc_en_i) begin
            if (jump_en_i)                  pc_d = jump_i;
            else if (pc_q == wrap_bottom_i) pc_d = wrap_top_i;
            else                            pc_d = pc_q + 5'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) pc_q <= '0;
        else     pc_q <= pc_d;
    end

    assign pc_o = pc_q;
endmodule

module pio_sm_fifo #(
    parameter  int DEPTH = 4,
    parameter  int DW    = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [DW-1:0] data_i,
    input  logic          pop_i,
    output logic [DW-1:0] data_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   count_o
);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;
    logic          push_ok, pop_ok;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == FULL_CNT);
    assign pop_ok  = pop_i && !empty_o;
    // A full FIFO still accepts a push when the same cycle frees a slot.
    assign push_ok = push_i && (!full_o || pop_ok);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_ok) wr_q <= wr_q + AW'(1);
            if (pop_ok)  rd_q <= rd_q + AW'(1);
            if (push_ok && !pop_ok)      cnt_q <= cnt_q + (AW+1)'(1);
            else if (pop_ok && !push_ok) cnt_q <= cnt_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_q] <= data_i;
    end

    assign data_o  = empty_o ? '0 : mem_q[rd_q];
    assign count_o = cnt_q;
endmodule

module pio_sm_osr (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  mov_i,
    input  logic [31:0] mov_data_i,
    input  logic        pull_i,
    input  logic        shift_en_i,
    input  logic [4:0]  shift_count_i,
    input  logic        shiftdir_i,
    input  logic        autopull_i,
    input  logic [4:0]  pull_thresh_i,
    input  logic        tx_empty_i,
    input  logic [31:0] tx_head_i,
    output logic        tx_pop_o,
    output logic [31:0] osr_o,
    output logic [31:0] data_out_o,
    output logic [5:0]  shift_cnt_o,
    output logic        empty_o,
    output logic        pulled_o
);
    logic [31:0] osr_q, osr_d, dout_q, dout_d;
    logic [5:0]  cnt_q, cnt_d, thresh_eff, n;
    logic [6:0]  cnt_sum;
    logic        pulled_q, mov_ld, auto_req, pull_req, do_shift;

    assign thresh_eff = (pull_thresh_i == 5'd0) ? 6'd32 : {1'b0, pull_thresh_i};
    assign n          = (shift_count_i == 5'd0) ? 6'd32 : {1'b0, shift_count_i};
    assign empty_o    = (cnt_q >= thresh_eff);

`ifdef OSR_AUTOPULL_EN
    assign auto_req = autopull_i && empty_o;
`else
    logic unused_autopull;
    assign unused_autopull = autopull_i;
    assign auto_req        = 1'b0;
`endif

    // Priority: MOV load, then pull (even an unserviceable one), then shift.
    assign mov_ld   = (mov_i == 2'b01);
    assign pull_req = pull_i || auto_req;
    assign tx_pop_o = !mov_ld && pull_req && !tx_empty_i;
    assign do_shift = !mov_ld && !pull_req && shift_en_i;
    assign cnt_sum  = {1'b0, cnt_q} + {1'b0, n};

    always_comb begin
        osr_d  = osr_q;
        cnt_d  = cnt_q;
        dout_d = dout_q;
        if (mov_ld) begin
            osr_d = mov_data_i;
            cnt_d = '0;
        end else if (tx_pop_o) begin
            osr_d = tx_head_i;
            cnt_d = '0;
        end else if (do_shift) begin
            if (shiftdir_i) begin
                dout_d = osr_q & ~(32'hFFFF_FFFF << n);
                osr_d  = osr_q >> n;
            end else begin
                dout_d = osr_q >> (6'd32 - n);
                osr_d  = osr_q << n;
            end
            cnt_d = (cnt_sum > 7'd32) ? 6'd32 : cnt_sum[5:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            osr_q    <= '0;
            dout_q   <= '0;
            cnt_q    <= 6'd32;
            pulled_q <= 1'b0;
        end else begin
            osr_q    <= osr_d;
            dout_q   <= dout_d;
            cnt_q    <= cnt_d;
            pulled_q <= tx_pop_o;
        end
    end

    assign osr_o       = osr_q;
    assign data_out_o  = dout_q;
    assign shift_cnt_o = cnt_q;
    assign pulled_o    = pulled_q;
endmodule

module pio_sm_datapath #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  wrap_top,
    input  logic [4:0]  wrap_bottom,
    input  logic [4:0]  jump,
    input  logic        jump_en,
    input  logic        pc_en,
    output logic [4:0]  pc,
    input  logic        tx_push_en,
    input  logic [31:0] tx_data_in,
    output logic [1:0]  tx_status,
    output logic [2:0]  tx_fifo_count,
    input  logic        rx_push_en,
    input  logic [31:0] rx_data_in,
    input  logic        rx_pop_en,
    output logic [31:0] rx_data_out,
    output logic [1:0]  rx_status,
    output logic [2:0]  rx_fifo_count,
    input  logic [1:0]  osr_mov,
    input  logic [31:0] osr_mov_in,
    output logic [31:0] osr_mov_out,
    input  logic        osr_pull,
    input  logic        shift_en,
    input  logic [4:0]  shift_count,
    input  logic        shiftdir,
    input  logic        autopull,
    input  logic [4:0]  pull_thresh,
    output logic [31:0] osr_data_out,
    output logic [5:0]  osr_shift_cnt,
    output logic        osr_empty,
    output logic        osr_pulled
);
    logic        tx_pop, tx_full, tx_empty, rx_full, rx_empty;
    logic [31:0] tx_head;

    pio_sm_pc u_pc (
        .clk(clk), .rst(rst), .pc_en_i(pc_en), .jump_en_i(jump_en), .jump_i(jump),
        .wrap_top_i(wrap_top), .wrap_bottom_i(wrap_bottom), .pc_o(pc)
    );

    pio_sm_fifo #(.DEPTH(FIFO_DEPTH), .DW(32)) u_tx_fifo (
        .clk(clk), .rst(rst), .push_i(tx_push_en), .data_i(tx_data_in), .pop_i(tx_pop),
        .data_o(tx_head), .full_o(tx_full), .empty_o(tx_empty), .count_o(tx_fifo_count)
    );

    pio_sm_fifo #(.DEPTH(FIFO_DEPTH), .DW(32)) u_rx_fifo (
        .clk(clk), .rst(rst), .push_i(rx_push_en), .data_i(rx_data_in), .pop_i(rx_pop_en),
        .data_o(rx_data_out), .full_o(rx_full), .empty_o(rx_empty), .count_o(rx_fifo_count)
    );

    pio_sm_osr u_osr (
        .clk(clk), .rst(rst), .mov_i(osr_mov), .mov_data_i(osr_mov_in), .pull_i(osr_pull),
        .shift_en_i(shift_en), .shift_count_i(shift_count), .shiftdir_i(shiftdir),
        .autopull_i(autopull), .pull_thresh_i(pull_thresh), .tx_empty_i(tx_empty),
        .tx_head_i(tx_head), .tx_pop_o(tx_pop), .osr_o(osr_mov_out),
        .data_out_o(osr_data_out), .shift_cnt_o(osr_shift_cnt), .empty_o(osr_empty),
        .pulled_o(osr_pulled)
    );

    assign tx_status = {tx_full, tx_empty};
    assign rx_status = {rx_full, rx_empty};
endmodule

// File: tb/tb_pio_sm_datapath.sv
// Bench for pio_sm_datapath: PC vector table, hand-written FIFO/OSR sequences, and random
// stimulus checked every cycle against a queue-based reference model.
module tb_pio_sm_datapath;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, jump_en, pc_en, tx_push_en, rx_push_en, rx_pop_en;
    logic        osr_pull, shift_en, shiftdir, autopull;
    logic [4:0]  wrap_top, wrap_bottom, jump, pc, shift_count, pull_thresh;
    logic [31:0] tx_data_in, rx_data_in, rx_data_out, osr_mov_in, osr_mov_out, osr_data_out;
    logic [1:0]  tx_status, rx_status, osr_mov;
    logic [2:0]  tx_fifo_count, rx_fifo_count;
    logic [5:0]  osr_shift_cnt;
    logic        osr_empty, osr_pulled;

    pio_sm_datapath dut (
        .clk(clk), .rst(rst), .wrap_top(wrap_top), .wrap_bottom(wrap_bottom), .jump(jump),
        .jump_en(jump_en), .pc_en(pc_en), .pc(pc), .tx_push_en(tx_push_en),
        .tx_data_in(tx_data_in), .tx_status(tx_status), .tx_fifo_count(tx_fifo_count),
        .rx_push_en(rx_push_en), .rx_data_in(rx_data_in), .rx_pop_en(rx_pop_en),
        .rx_data_out(rx_data_out), .rx_status(rx_status), .rx_fifo_count(rx_fifo_count),
        .osr_mov(osr_mov), .osr_mov_in(osr_mov_in), .osr_mov_out(osr_mov_out),
        .osr_pull(osr_pull), .shift_en(shift_en), .shift_count(shift_count),
        .shiftdir(shiftdir), .autopull(autopull), .pull_thresh(pull_thresh),
        .osr_data_out(osr_data_out), .osr_shift_cnt(osr_shift_cnt), .osr_empty(osr_empty),
        .osr_pulled(osr_pulled)
    );

    typedef struct packed {
        logic        rst, pc_en, jump_en;
        logic [4:0]  jump, wtop, wbot;
        logic        txp;
        logic [31:0] txd;
        logic        rxp;
        logic [31:0] rxd;
        logic        rxpop;
        logic [1:0]  mov;
        logic [31:0] movin;
        logic        pull, sh;
        logic [4:0]  sc;
        logic        dir, ap;
        logic [4:0]  thr;
    } in_t;

    typedef struct packed {
        logic       pc_en, jump_en;
        logic [4:0] jump, wtop, wbot, exp_pc;
    } pcvec_t;

    in_t    cur;
    pcvec_t pc_tbl [10];
    int     checks = 0;
    int     errors = 0;

    // Reference model state
    int          m_pc, m_cnt, m_thr;
    logic [31:0] txq [$];
    logic [31:0] rxq [$];
    logic [31:0] m_osr, m_dout;
    bit          m_pulled;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive();
        rst = cur.rst; pc_en = cur.pc_en; jump_en = cur.jump_en; jump = cur.jump;
        wrap_top = cur.wtop; wrap_bottom = cur.wbot;
        tx_push_en = cur.txp; tx_data_in = cur.txd;
        rx_push_en = cur.rxp; rx_data_in = cur.rxd; rx_pop_en = cur.rxpop;
        osr_mov = cur.mov; osr_mov_in = cur.movin; osr_pull = cur.pull;
        shift_en = cur.sh; shift_count = cur.sc; shiftdir = cur.dir;
        autopull = cur.ap; pull_thresh = cur.thr;
    endtask

    function automatic longint unsigned pow2(input int k);
        longint unsigned p = 1;
        for (int i = 0; i < k; i++) p = p * 2;
        return p;
    endfunction

    task automatic model_step();
        bit pull_req, pop, rx_pop_ok;
        int n;
        longint unsigned o;
        m_thr = (cur.thr == 0) ? 32 : int'(cur.thr);
        if (cur.rst) begin
            m_pc = 0; txq.delete(); rxq.delete();
            m_osr = 0; m_dout = 0; m_cnt = 32; m_pulled = 0;
            return;
        end
        if (cur.pc_en) begin
            if (cur.jump_en)                m_pc = cur.jump;
            else if (m_pc == int'(cur.wbot)) m_pc = cur.wtop;
            else                            m_pc = (m_pc + 1) % 32;
        end
        pull_req = cur.pull;
`ifdef OSR_AUTOPULL_EN
        if (cur.ap && m_cnt >= m_thr) pull_req = 1;
`endif
        pop = 0;
        if (cur.mov == 2'b01) begin
            m_osr = cur.movin; m_cnt = 0;
        end else if (pull_req) begin
            if (txq.size() > 0) begin
                m_osr = txq[0]; m_cnt = 0; pop = 1;
            end
        end else if (cur.sh) begin
            n = (cur.sc == 0) ? 32 : int'(cur.sc);
            o = m_osr;
            if (cur.dir) begin
                m_dout = 32'(o % pow2(n));
                m_osr  = 32'(o / pow2(n));
            end else begin
                m_dout = 32'(o / pow2(32 - n));
                m_osr  = 32'((o * pow2(n)) % pow2(32));
            end
            m_cnt = (m_cnt + n > 32) ? 32 : m_cnt + n;
        end
        m_pulled = pop;
        if (cur.txp && (txq.size() < 4 || pop)) begin
            if (pop) void'(txq.pop_front());
            txq.push_back(cur.txd);
        end else if (pop) void'(txq.pop_front());
        rx_pop_ok = cur.rxpop && rxq.size() > 0;
        if (rx_pop_ok) void'(rxq.pop_front());
        if (cur.rxp && (rxq.size() < 4 || rx_pop_ok)) rxq.push_back(cur.rxd);
    endtask

    task automatic check_model();
        chk("pc", 32'(pc), 32'(m_pc));
        chk("tx_status", 32'(tx_status), {30'd0, txq.size() == 4, txq.size() == 0});
        chk("tx_count", 32'(tx_fifo_count), txq.size());
        chk("rx_status", 32'(rx_status), {30'd0, rxq.size() == 4, rxq.size() == 0});
        chk("rx_count", 32'(rx_fifo_count), rxq.size());
        chk("rx_data_out", rx_data_out, (rxq.size() > 0) ? rxq[0] : 32'd0);
        chk("osr", osr_mov_out, m_osr);
        chk("osr_data_out", osr_data_out, m_dout);
        chk("osr_shift_cnt", 32'(osr_shift_cnt), 32'(m_cnt));
        chk("osr_empty", 32'(osr_empty), 32'(m_cnt >= m_thr));
        chk("osr_pulled", 32'(osr_pulled), 32'(m_pulled));
    endtask

    task automatic cycle();
        drive();
        model_step();
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic do_reset();
        cur = '0; cur.rst = 1; cycle(); cur = '0;
    endtask

    initial begin
        pc_tbl[0] = '{1'b1, 1'b0, 5'd0,  5'd2, 5'd5, 5'd1};
        pc_tbl[1] = '{1'b1, 1'b0, 5'd0,  5'd2, 5'd5, 5'd2};
        pc_tbl[2] = '{1'b1, 1'b0, 5'd0,  5'd2, 5'd5, 5'd3};
        pc_tbl[3] = '{1'b1, 1'b0, 5'd0,  5'd2, 5'd5, 5'd4};
        pc_tbl[4] = '{1'b1, 1'b0, 5'd0,  5'd2, 5'd5, 5'd5};
        pc_tbl[5] = '{1'b1, 1'b0, 5'd0,  5'd2, 5'd5, 5'd2};
        pc_tbl[6] = '{1'b1, 1'b1, 5'd17, 5'd2, 5'd5, 5'd17};
        pc_tbl[7] = '{1'b0, 1'b1, 5'd3,  5'd2, 5'd5, 5'd17};
        pc_tbl[8] = '{1'b1, 1'b1, 5'd31, 5'd2, 5'd5, 5'd31};
        pc_tbl[9] = '{1'b1, 1'b0, 5'd0,  5'd2, 5'd5, 5'd0};

        // Reset state
        do_reset();
        chk("rst pc", 32'(pc), 0);
        chk("rst tx_status", 32'(tx_status), 1);
        chk("rst tx_count", 32'(tx_fifo_count), 0);
        chk("rst rx_status", 32'(rx_status), 1);
        chk("rst rx_data", rx_data_out, 0);
        chk("rst osr", osr_mov_out, 0);
        chk("rst shift_cnt", 32'(osr_shift_cnt), 32);
        chk("rst data_out", osr_data_out, 0);
        chk("rst pulled", 32'(osr_pulled), 0);

        // PC wrap, jump, stall and 31->0 rollover
        for (int i = 0; i < 10; i++) begin
            cur = '0;
            cur.pc_en = pc_tbl[i].pc_en; cur.jump_en = pc_tbl[i].jump_en;
            cur.jump = pc_tbl[i].jump; cur.wtop = pc_tbl[i].wtop; cur.wbot = pc_tbl[i].wbot;
            cycle();
            chk($sformatf("pc_tbl[%0d]", i), 32'(pc), 32'(pc_tbl[i].exp_pc));
        end

        // TX fill with overflow, drain through pulls, then push+pop while full
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cur = '0; cur.txp = 1; cur.txd = 32'h100 + i; cycle();
        end
        chk("tx full count", 32'(tx_fifo_count), 4);
        chk("tx full status", 32'(tx_status), 2);
        for (int i = 0; i < 4; i++) begin
            cur = '0; cur.pull = 1; cycle();
            chk($sformatf("drain osr %0d", i), osr_mov_out, 32'h100 + i);
            chk($sformatf("drain pulled %0d", i), 32'(osr_pulled), 1);
        end
        chk("drained status", 32'(tx_status), 1);
        cur = '0; cur.pull = 1; cycle();
        chk("pull empty osr", osr_mov_out, 32'h103);
        chk("pull empty pulled", 32'(osr_pulled), 0);
        for (int i = 0; i < 4; i++) begin
            cur = '0; cur.txp = 1; cur.txd = 32'h200 + i; cycle();
        end
        cur = '0; cur.txp = 1; cur.txd = 32'h204; cur.pull = 1; cycle();
        chk("push+pop full count", 32'(tx_fifo_count), 4);
        chk("push+pop full osr", osr_mov_out, 32'h200);

        // Pull then right/left/32-bit shifts
        do_reset();
        cur = '0; cur.txp = 1; cur.txd = 32'hA5A5_0F0F; cycle();
        cur = '0; cur.pull = 1; cycle();
        chk("pull osr", osr_mov_out, 32'hA5A5_0F0F);
        chk("pull cnt", 32'(osr_shift_cnt), 0);
        chk("pull pulse", 32'(osr_pulled), 1);
        cur = '0; cur.sh = 1; cur.sc = 8; cur.dir = 1; cycle();
        chk("shr8 data", osr_data_out, 32'h0F);
        chk("shr8 cnt", 32'(osr_shift_cnt), 8);
        chk("pulse ends", 32'(osr_pulled), 0);
        cur = '0; cur.sh = 1; cur.sc = 4; cur.dir = 0; cycle();
        chk("shl4 data", osr_data_out, 32'h0);
        chk("shl4 osr", osr_mov_out, 32'h0A5A_50F0);
        cur = '0; cur.sh = 1; cur.sc = 0; cur.dir = 1; cycle();
        chk("shr32 data", osr_data_out, 32'h0A5A_50F0);
        chk("shr32 cnt sat", 32'(osr_shift_cnt), 32);

        // MOV beats pull and shift
        do_reset();
        cur = '0; cur.txp = 1; cur.txd = 32'h11; cycle();
        cur = '0; cur.mov = 2'b01; cur.movin = 32'hDEAD_BEEF; cur.pull = 1; cur.sh = 1; cycle();
        chk("mov osr", osr_mov_out, 32'hDEAD_BEEF);
        chk("mov tx count", 32'(tx_fifo_count), 1);
        chk("mov cnt", 32'(osr_shift_cnt), 0);

        // RX: push+pop on empty, then show-ahead order
        do_reset();
        cur = '0; cur.rxp = 1; cur.rxd = 32'hAAAA_0001; cur.rxpop = 1; cycle();
        chk("rx push+pop empty", 32'(rx_fifo_count), 1);
        cur = '0; cur.rxp = 1; cur.rxd = 32'hBBBB_0002; cycle();
        chk("rx head", rx_data_out, 32'hAAAA_0001);
        cur = '0; cur.rxpop = 1; cycle();
        chk("rx head after pop", rx_data_out, 32'hBBBB_0002);
        cur = '0; cur.rxpop = 1; cycle();
        cur = '0; cur.rxpop = 1; cycle();
        chk("rx pop empty count", 32'(rx_fifo_count), 0);
        chk("rx empty data", rx_data_out, 0);

`ifdef OSR_AUTOPULL_EN
        do_reset();
        cur = '0; cur.ap = 1; cur.thr = 8; cur.mov = 2'b01; cur.movin = 32'hCAFE_F00D; cycle();
        cur = '0; cur.ap = 1; cur.thr = 8; cur.txp = 1; cur.txd = 32'h1234_5678; cycle();
        cur = '0; cur.ap = 1; cur.thr = 8; cur.sh = 1; cur.sc = 8; cur.dir = 1; cycle();
        chk("ap shift data", osr_data_out, 32'h0D);
        chk("ap empty flag", 32'(osr_empty), 1);
        cur = '0; cur.ap = 1; cur.thr = 8; cycle();
        chk("autopull osr", osr_mov_out, 32'h1234_5678);
        chk("autopull tx count", 32'(tx_fifo_count), 0);
        chk("autopull pulse", 32'(osr_pulled), 1);
`endif

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            int m;
            cur = '0;
            cur.rst = ($urandom_range(0, 99) == 0);
            cur.pc_en = $urandom_range(0, 1);
            cur.jump_en = ($urandom_range(0, 3) == 0);
            cur.jump = 5'($urandom); cur.wtop = 5'($urandom); cur.wbot = 5'($urandom);
            cur.txp = ($urandom_range(0, 9) < 4); cur.txd = $urandom;
            cur.rxp = ($urandom_range(0, 9) < 4); cur.rxd = $urandom;
            cur.rxpop = ($urandom_range(0, 9) < 4);
            m = $urandom_range(0, 9);
            cur.mov = (m == 0) ? 2'b01 : (m == 1) ? 2'b10 : (m == 2) ? 2'b11 : 2'b00;
            cur.movin = $urandom;
            cur.pull = ($urandom_range(0, 4) == 0);
            cur.sh = $urandom_range(0, 1);
            cur.sc = 5'($urandom); cur.dir = $urandom_range(0, 1);
            cur.ap = $urandom_range(0, 1); cur.thr = 5'($urandom);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
